// File: rtl/seq_pattern_tx_pkg.sv
// Shared constants for the serial pattern transmitter: FSM encoding and
// the level the serial line rests at when no pattern bit is being sent.
package seq_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } tx_state_e;

  // Line rests high so a downstream sequence detector stays idle.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/data bundle of the serial pattern transmitter. The master side
// requests frames and watches the line; the slave side is the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern_in;
  logic [CNT_W-1:0] repeat_n;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern_in, repeat_n,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern_in, repeat_n,
    output dout, dout_valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx_shreg.sv
// PAT_W-bit load/shift register whose head bit drives the serial line
// directly. Vacated positions fill with the idle level, so a register
// loaded with all idle bits (or fully shifted out) reads as an idle line.
module seq_tx_shreg
  import seq_tx_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_val,
  output logic             bit_out
);

  logic [PAT_W-1:0] shreg_q;
  logic [PAT_W-1:0] shreg_d;

  // Next register contents: a load wins over a shift.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        shreg_d = {shreg_q[PAT_W-2:0], LINE_IDLE};
      end else begin
        shreg_d = {LINE_IDLE, shreg_q[PAT_W-1:1]};
      end
    end
  end

  // Register resets to the idle level so the line is high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= {PAT_W{LINE_IDLE}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit_out = (MSB_FIRST != 0) ? shreg_q[PAT_W-1] : shreg_q[0];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern one bit
// per clock, repeat_n+1 times, with optional idle gap bits between
// repetitions. All outputs come straight from flops.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int CNT_W     = 4,
  parameter int GAP_BITS  = 0,
  parameter int MSB_FIRST = 1
) (
  input logic              clk,
  input logic              reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int BIT_CW = $clog2(PAT_W);
  localparam int GAP_CW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam int BIT_LAST_I = PAT_W - 1;
  localparam int GAP_LAST_I = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_LAST_I[BIT_CW-1:0];
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_LAST_I[GAP_CW-1:0];

  tx_state_e         state_q, state_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sh_load;
  logic              sh_shift;
  logic [PAT_W-1:0]  sh_load_val;
  logic              sh_bit;

  // The line itself lives in the shift register; idle cycles reload it
  // with all idle bits so dout is high whenever nothing is being sent.
  seq_tx_shreg #(
    .PAT_W     (PAT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_load_val),
    .bit_out  (sh_bit)
  );

  // Next-state and next-output logic; outputs describe the coming cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    pat_d       = pat_q;
    sh_load     = 1'b1;
    sh_shift    = 1'b0;
    sh_load_val = {PAT_W{LINE_IDLE}};
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            pat_d       = bus.pattern_in;
            rep_cnt_d   = bus.repeat_n;
            bit_cnt_d   = '0;
            sh_load_val = bus.pattern_in;
            valid_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = SEND;
          end
        end
        SEND: begin
          if (bit_cnt_q != BIT_LAST) begin
            sh_load   = 1'b0;
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            if (GAP_BITS > 0) begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end else begin
              sh_load_val = pat_q;
              valid_d     = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        GAP: begin
          busy_d = 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            sh_load_val = pat_q;
            valid_d     = 1'b1;
            state_d     = SEND;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters, captured pattern and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.dout       = sh_bit;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx. Three instances cover the default
// configuration, a two-bit inter-repetition gap and LSB-first ordering.
// Observed outputs are packed as {dout, dout_valid, busy, done}.
module tb_seq_pattern_tx;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ifa ();
  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ifg ();
  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ifl ();

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_BITS(0), .MSB_FIRST(1)) dut_a (
    .clk (clk), .reset (reset_n), .bus (ifa)
  );
  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_BITS(2), .MSB_FIRST(1)) dut_g (
    .clk (clk), .reset (reset_n), .bus (ifg)
  );
  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_BITS(0), .MSB_FIRST(0)) dut_l (
    .clk (clk), .reset (reset_n), .bus (ifl)
  );

  wire [3:0] obs_a = {ifa.dout, ifa.dout_valid, ifa.busy, ifa.done};
  wire [3:0] obs_g = {ifg.dout, ifg.dout_valid, ifg.busy, ifg.done};
  wire [3:0] obs_l = {ifl.dout, ifl.dout_valid, ifl.busy, ifl.done};

  localparam logic [3:0] IDLE_V = 4'b1000;
  localparam logic [3:0] DONE_V = 4'b1001;
  localparam logic [3:0] GAP_V  = 4'b1010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed dout/valid/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] exp12;
    logic [9:0]  exp_dout_g;
    logic [9:0]  exp_valid_g;
    logic [3:0]  pat_max;

    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.pattern_in = '0; ifa.repeat_n = '0;
    ifg.start = 1'b0; ifg.abort = 1'b0; ifg.pattern_in = '0; ifg.repeat_n = '0;
    ifl.start = 1'b0; ifl.abort = 1'b0; ifl.pattern_in = '0; ifl.repeat_n = '0;

    // Reset values
    #12;
    check_output("reset a", obs_a, IDLE_V);
    check_output("reset g", obs_g, IDLE_V);
    check_output("reset l", obs_l, IDLE_V);
    #10 reset_n = 1'b1;
    tick();
    check_output("post-reset idle", obs_a, IDLE_V);

    // Single 0110 frame, MSB first
    $display("[TB] single frame 0110");
    ifa.pattern_in = 4'b0110; ifa.repeat_n = 4'd0; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    check_output("t1 c1", obs_a, 4'b0110);
    tick(); check_output("t1 c2", obs_a, 4'b1110);
    tick(); check_output("t1 c3", obs_a, 4'b1110);
    tick(); check_output("t1 c4", obs_a, 4'b0110);
    tick(); check_output("t1 done", obs_a, DONE_V);
    tick(); check_output("t1 after", obs_a, IDLE_V);

    // Three back-to-back repetitions with start re-pulsed in SEND and DONE
    $display("[TB] repeat 3 back-to-back");
    exp12 = 12'b011001100110;
    ifa.pattern_in = 4'b0110; ifa.repeat_n = 4'd2; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("t2 bit%0d", i), obs_a, {exp12[11-i], 3'b110});
      if (i == 4) begin
        ifa.start = 1'b1; ifa.pattern_in = 4'b1111; ifa.repeat_n = 4'd0;
      end else begin
        ifa.start = 1'b0;
      end
      tick();
    end
    check_output("t2 done", obs_a, DONE_V);
    ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    check_output("t2 start in done", obs_a, IDLE_V);
    tick(); check_output("t2 still idle", obs_a, IDLE_V);

    // Gap instance: two idle bits between repetitions
    $display("[TB] gap of two bits");
    exp_dout_g  = 10'b0110110110;
    exp_valid_g = 10'b1111001111;
    ifg.pattern_in = 4'b0110; ifg.repeat_n = 4'd1; ifg.start = 1'b1;
    tick(); ifg.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("t3 c%0d", i + 1), obs_g,
                   {exp_dout_g[9-i], exp_valid_g[9-i], 2'b10});
      tick();
    end
    check_output("t3 done", obs_g, DONE_V);
    tick(); check_output("t3 after", obs_g, IDLE_V);
    check_output("t3 gap value", 4'b1010, GAP_V);

    // LSB-first instance
    $display("[TB] lsb first 0001");
    ifl.pattern_in = 4'b0001; ifl.repeat_n = 4'd0; ifl.start = 1'b1;
    tick(); ifl.start = 1'b0;
    check_output("t4 c1", obs_l, 4'b1110);
    tick(); check_output("t4 c2", obs_l, 4'b0110);
    tick(); check_output("t4 c3", obs_l, 4'b0110);
    tick(); check_output("t4 c4", obs_l, 4'b0110);
    tick(); check_output("t4 done", obs_l, DONE_V);

    // Abort on the second bit
    $display("[TB] abort mid-frame");
    ifa.pattern_in = 4'b0110; ifa.repeat_n = 4'd0; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    check_output("t5 c1", obs_a, 4'b0110);
    tick(); check_output("t5 c2", obs_a, 4'b1110);
    ifa.abort = 1'b1;
    tick(); ifa.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t5 aborted %0d", i), obs_a, IDLE_V);
      tick();
    end

    // Abort and start together in IDLE
    $display("[TB] abort with start");
    ifa.start = 1'b1; ifa.abort = 1'b1;
    tick(); ifa.start = 1'b0; ifa.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t6 idle %0d", i), obs_a, IDLE_V);
      tick();
    end

    // Asynchronous reset mid-frame, then a clean frame
    $display("[TB] reset mid-frame");
    ifa.pattern_in = 4'b0110; ifa.repeat_n = 4'd3; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    tick(); check_output("t7 c2", obs_a, 4'b1110);
    #2 reset_n = 1'b0;
    #1 check_output("t7 async reset", obs_a, IDLE_V);
    #20 reset_n = 1'b1;
    tick(); check_output("t7 released", obs_a, IDLE_V);
    ifa.pattern_in = 4'b1011; ifa.repeat_n = 4'd0; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0;
    check_output("t7 c1", obs_a, 4'b1110);
    tick(); check_output("t7 c2b", obs_a, 4'b0110);
    tick(); check_output("t7 c3", obs_a, 4'b1110);
    tick(); check_output("t7 c4", obs_a, 4'b1110);
    tick(); check_output("t7 done", obs_a, DONE_V);

    // Maximum repeat count: 16 repetitions of 1001
    $display("[TB] max repeat");
    tick();
    pat_max = 4'b1001;
    ifa.pattern_in = pat_max; ifa.repeat_n = 4'd15; ifa.start = 1'b1;
    tick(); ifa.start = 1'b0; ifa.pattern_in = 4'b0000;
    for (int i = 0; i < 64; i++) begin
      check_output($sformatf("t8 bit%0d", i), obs_a, {pat_max[3 - (i % 4)], 3'b110});
      tick();
    end
    check_output("t8 done", obs_a, DONE_V);
    tick(); check_output("t8 after", obs_a, IDLE_V);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
